// File: rtl/fpaddsub_norm_stage_pkg.sv
// Shared types and constants for the FP add/sub normalisation stage.
package fpaddsub_pkg;

  localparam int MAN_W = 32;
  localparam int EXP_W = 8;
  localparam int LZ_W  = 6;
  localparam int SH_W  = $clog2(MAN_W);

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  // One normalised beat as presented to the rounding stage.
  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             unf;
    logic             ovf;
  } norm_beat_t;

  // Beat held between S1 and S2: raw sum plus the decided shift and exponent.
  typedef struct packed {
    logic [MAN_W-1:0] sum;
    logic [SH_W-1:0]  shamt;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             unf;
    logic             ovf;
  } s1_beat_t;

  // Priority encoder: number of zeros above the leading one; MAN_W for an all-zero word.
  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (v[i]) n = LZ_W'(MAN_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpaddsub_norm_stage_if.sv
// Beat bus of the normalisation stage: upstream inputs and downstream outputs.
interface fpaddsub_norm_stage_if;
  import fpaddsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] in_sum;
  logic [LZ_W-1:0]  in_lz;
  logic [EXP_W-1:0] in_exp;
  logic             in_sign;

  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] out_man;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_unf;
  logic             out_ovf;

  // The stage itself.
  modport slave (
    input  in_valid, in_sum, in_lz, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_man, out_exp, out_sign, out_zero, out_unf, out_ovf
  );

  // Whoever feeds and drains the stage.
  modport master (
    output in_valid, in_sum, in_lz, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_man, out_exp, out_sign, out_zero, out_unf, out_ovf
  );

endinterface

// File: rtl/fpaddsub_norm_shifter.sv
// Combinational logarithmic left barrel shifter, one mux level per shift-amount bit.
module fpaddsub_norm_shifter #(
  parameter int MAN_W = 32
) (
  input  logic [MAN_W-1:0]         i_data,
  input  logic [$clog2(MAN_W)-1:0] i_shamt,
  output logic [MAN_W-1:0]         o_data
);

  localparam int LVL = $clog2(MAN_W);

  logic [MAN_W-1:0] w_stage [0:LVL];

  assign w_stage[0] = i_data;

  // Level gi shifts by 2^gi when bit gi of the amount is set.
  generate
    for (genvar gi = 0; gi < LVL; gi++) begin : g_lvl
      assign w_stage[gi+1] = i_shamt[gi] ? (w_stage[gi] << (2 ** gi)) : w_stage[gi];
    end
  endgenerate

  assign o_data = w_stage[LVL];

endmodule

// File: rtl/fpaddsub_norm_stage.sv
// Normalisation stage of the FP add/sub datapath: two-stage valid/ready pipeline.
// S1 decides shift amount, exponent and flags; S2 shifts and applies zero/overflow forcing.
// Build option FPADDSUB_NORM_INTERNAL_LZC_EN: derive the leading-zero count from the sum
// itself instead of trusting in_lz.
module fpaddsub_norm_stage
  import fpaddsub_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  fpaddsub_norm_stage_if.slave bus
);

  localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'(2 ** EXP_W - 1);

  logic             r_v1;
  logic             r_v2;
  s1_beat_t         r_s1;
  norm_beat_t       r_s2;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [LZ_W-1:0]  w_lz;
  logic signed [EXP_W+1:0] w_e;
  s1_beat_t         w_s1_next;
  norm_beat_t       w_s2_next;
  logic [MAN_W-1:0] w_shifted;

`ifdef FPADDSUB_NORM_INTERNAL_LZC_EN
  assign w_lz = lzc(bus.in_sum);
`else
  assign w_lz = bus.in_lz;
`endif

  // S2 advances when empty or draining; S1 advances when empty or S2 advances.
  assign w_s2_en      = !r_v2 || bus.out_ready;
  assign w_s1_en      = !r_v1 || w_s2_en;
  assign bus.in_ready = w_s1_en;

  // S1: exponent adjust on a signed, widened range so underflow and overflow are visible.
  always_comb begin
    w_s1_next       = '0;
    w_e             = (EXP_W+2)'(bus.in_exp) + (EXP_W+2)'(1) - (EXP_W+2)'(w_lz);
    w_s1_next.sum   = bus.in_sum;
    w_s1_next.sign  = bus.in_sign;
    w_s1_next.zero  = (w_lz >= LZ_W'(MAN_W));
    w_s1_next.shamt = w_lz[SH_W-1:0];
    w_s1_next.exp   = w_e[EXP_W-1:0];
    if (w_s1_next.zero) begin
      w_s1_next.shamt = '0;
    end else if (w_e < E_ONE) begin
      // Denormal clamp: only shift as far as the exponent allows.
      w_s1_next.unf   = 1'b1;
      w_s1_next.shamt = bus.in_exp[SH_W-1:0];
      w_s1_next.exp   = '0;
    end
    w_s1_next.ovf = !w_s1_next.zero && (w_e >= E_MAX);
  end

  fpaddsub_norm_shifter #(.MAN_W(MAN_W)) u_shifter (
    .i_data  (r_s1.sum),
    .i_shamt (r_s1.shamt),
    .o_data  (w_shifted)
  );

  // S2: zero forces an all-zero result; overflow saturates the exponent and clears the mantissa.
  always_comb begin
    w_s2_next      = '0;
    w_s2_next.sign = r_s1.sign;
    w_s2_next.zero = r_s1.zero;
    w_s2_next.unf  = r_s1.unf && !r_s1.zero;
    w_s2_next.ovf  = r_s1.ovf && !r_s1.zero;
    if (r_s1.zero) begin
      w_s2_next.man = '0;
      w_s2_next.exp = '0;
    end else if (r_s1.ovf) begin
      w_s2_next.man = '0;
      w_s2_next.exp = EXP_ALL_ONES;
    end else begin
      w_s2_next.man = w_shifted;
      w_s2_next.exp = r_s1.exp;
    end
  end

  // Pipeline registers; data only loads with a valid beat so held outputs never change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      if (w_s1_en) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) r_s1 <= w_s1_next;
      end
      if (w_s2_en) begin
        r_v2 <= r_v1;
        if (r_v1) r_s2 <= w_s2_next;
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.out_man   = r_s2.man;
  assign bus.out_exp   = r_s2.exp;
  assign bus.out_sign  = r_s2.sign;
  assign bus.out_zero  = r_s2.zero;
  assign bus.out_unf   = r_s2.unf;
  assign bus.out_ovf   = r_s2.ovf;

endmodule
